// File: rtl/div_iter_radix2.sv
// rtl/div_iter_radix2.sv - iterative radix-2 restoring divider, {remainder, quotient} result
// Responder side of the opn_valid/res_valid/res_ready handshake; one quotient bit per clock.
module div_iter_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sign,
    input  logic               opn_valid,
    input  logic               res_ready,
    output logic               res_valid,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic               neg_rem_q, neg_rem_d;
    logic               neg_quo_q, neg_quo_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               valid_q, valid_d;

    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   quo_fix;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        a_d       = a_q;
        neg_rem_d = neg_rem_q;
        neg_quo_d = neg_quo_q;
        result_d  = result_q;
        shifted   = {rem_q, quo_q[WIDTH-1]};
        diff      = shifted - {1'b0, div_q};
        rem_fix   = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        quo_fix   = neg_quo_q ? (~quo_q + 1'b1) : quo_q;

        case (state_q)
            IDLE: begin
                if (opn_valid) begin
                    a_d       = a;
                    neg_rem_d = sign & a[WIDTH-1];
                    neg_quo_d = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                    quo_d     = (sign && a[WIDTH-1]) ? (~a + 1'b1) : a;
                    div_d     = (sign && b[WIDTH-1]) ? (~b + 1'b1) : b;
                    rem_d     = '0;
                    cnt_d     = '0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                // quo_q starts as the dividend magnitude; its MSB feeds the remainder each step
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                if (div_q == '0) begin
                    result_d = {a_q, {WIDTH{1'b1}}};
                end else begin
                    result_d = {rem_fix, quo_fix};
                end
                state_d = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            a_q       <= '0;
            neg_rem_q <= 1'b0;
            neg_quo_q <= 1'b0;
            result_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            a_q       <= a_d;
            neg_rem_q <= neg_rem_d;
            neg_quo_q <= neg_quo_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
        end
    end

    assign res_valid = valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_div_iter_radix2.sv
// tb/tb_div_iter_radix2.sv - directed self-checking bench for div_iter_radix2
// Hand-computed vectors covering latency, signs, overflow, divide-by-zero, backpressure and reset.
module tb_div_iter_radix2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        sign_i;
    logic        opn_valid;
    logic        res_ready;
    logic        res_valid;
    logic [63:0] result;

    int total = 0;
    int bad   = 0;

    div_iter_radix2 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a_i),
        .b         (b_i),
        .sign      (sign_i),
        .opn_valid (opn_valid),
        .res_ready (res_ready),
        .res_valid (res_valid),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts);
        @(negedge clk);
        a_i       = ta;
        b_i       = tb_v;
        sign_i    = ts;
        opn_valid = 1'b1;
        @(posedge clk);
        #1;
        opn_valid = 1'b0;
    endtask

    // Called just after the acceptance edge; counts edges until res_valid.
    task automatic wait_res(input string tag, input logic [63:0] exp, input bit scramble);
        int n;
        n = 0;
        while (!res_valid && n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (scramble) begin
                a_i    = $urandom;
                b_i    = $urandom;
                sign_i = 1'($urandom);
            end
        end
        check({tag, "_latency"}, 64'(n), 64'd33);
        check({tag, "_result"}, result, exp);
    endtask

    task automatic release_res(input string tag, input logic [63:0] exp, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, 64'(res_valid), 64'd1);
            check({tag, "_hold_result"}, result, exp);
        end
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check({tag, "_rel_valid"}, 64'(res_valid), 64'd0);
        check({tag, "_rel_result"}, result, exp);
    endtask

    initial begin
        rst       = 1'b1;
        a_i       = '0;
        b_i       = '0;
        sign_i    = 1'b0;
        opn_valid = 1'b0;
        res_ready = 1'b0;
        #1;
        check("reset_valid", 64'(res_valid), 64'd0);
        check("reset_result", result, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        accept(32'd100, 32'd7, 1'b0);
        wait_res("u100_7", 64'h00000002_0000000E, 1'b0);
        release_res("u100_7", 64'h00000002_0000000E, 0);

        accept(32'hFFFFFFF9, 32'd2, 1'b1);
        wait_res("s_m7_2", 64'hFFFFFFFF_FFFFFFFD, 1'b0);
        release_res("s_m7_2", 64'hFFFFFFFF_FFFFFFFD, 0);

        accept(32'hFFFFFFF9, 32'd2, 1'b0);
        wait_res("u_m7_2", 64'h00000001_7FFFFFFC, 1'b0);
        release_res("u_m7_2", 64'h00000001_7FFFFFFC, 0);

        accept(32'h80000000, 32'hFFFFFFFF, 1'b1);
        wait_res("s_ovf", 64'h00000000_80000000, 1'b0);
        release_res("s_ovf", 64'h00000000_80000000, 0);

        accept(32'h80000000, 32'hFFFFFFFF, 1'b0);
        wait_res("u_bigdiv", 64'h80000000_00000000, 1'b0);
        release_res("u_bigdiv", 64'h80000000_00000000, 0);

        accept(32'h12345678, 32'd0, 1'b1);
        wait_res("s_div0", 64'h12345678_FFFFFFFF, 1'b0);
        release_res("s_div0", 64'h12345678_FFFFFFFF, 0);

        accept(32'hF0000000, 32'd0, 1'b1);
        wait_res("s_div0_neg", 64'hF0000000_FFFFFFFF, 1'b0);
        release_res("s_div0_neg", 64'hF0000000_FFFFFFFF, 0);

        accept(32'd0, 32'd5, 1'b1);
        wait_res("zero_div", 64'h0, 1'b0);
        release_res("zero_div", 64'h0, 0);

        // 1000 / -3 signed: quotient -333, remainder +1
        accept(32'd1000, 32'hFFFFFFFD, 1'b1);
        wait_res("scramble", 64'h00000001_FFFFFEB3, 1'b1);
        release_res("scramble", 64'h00000001_FFFFFEB3, 5);

        // Back-to-back: a pending request during the release edge must wait one edge
        accept(32'd50, 32'd6, 1'b0);
        wait_res("b2b_first", 64'h00000002_00000008, 1'b0);
        @(negedge clk);
        res_ready = 1'b1;
        opn_valid = 1'b1;
        a_i       = 32'd100;
        b_i       = 32'd7;
        sign_i    = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_rel_valid", 64'(res_valid), 64'd0);
        @(posedge clk);
        #1;
        opn_valid = 1'b0;
        res_ready = 1'b0;
        wait_res("b2b_second", 64'h00000002_0000000E, 1'b0);
        release_res("b2b_second", 64'h00000002_0000000E, 0);

        // Asynchronous reset with counter at 10
        accept(32'd12345, 32'd10, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 64'(res_valid), 64'd0);
        check("rst_mid_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        accept(32'd100, 32'd7, 1'b0);
        wait_res("post_rst", 64'h00000002_0000000E, 1'b0);
        release_res("post_rst", 64'h00000002_0000000E, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
